maple_frame_packer: RTL and testbench

Upstream neighbour of the Maple bus bit encoder. Accepts a frame as a stream of 32-bit words (header word plus payload words, TLAST on the final word). Serialises each word into four bytes and appends one XOR checksum byte. Presents the result as an 8-bit AXI-Stream that the encoder consumes directly, with TLAST on the checksum byte.

---
 rtl/maple_frame_packer.sv | 155 +++++++++++++++
 tb/tb_maple_frame_packer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maple_frame_packer.sv
// rtl/maple_frame_packer.sv - packs 32-bit frame words into a byte stream with XOR checksum
//
// Purpose: serialises each accepted 32-bit word into four bytes (bits 7:0
// first) and closes every frame with an 8-bit XOR checksum byte carrying TLAST.
// Frames longer than MAX_WORDS are truncated: the checksum is sent after word
// MAX_WORDS and the remaining input words are swallowed up to their TLAST.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   S_AXIS_TVALID/TREADY/TLAST/TDATA[31:0]  input word stream
//   M_AXIS_TVALID/TREADY/TLAST/TDATA[7:0]   output byte stream (TLAST on checksum)
//   word_count[CNT_W-1:0]       words accepted in the current/last frame
//   frame_done                  one-cycle pulse after the checksum handshake
//   overflow                    one-cycle pulse when a frame is truncated
module maple_frame_packer #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic             S_AXIS_TLAST,
  input  logic [31:0]      S_AXIS_TDATA,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic             M_AXIS_TLAST,
  output logic [7:0]       M_AXIS_TDATA,
  output logic [CNT_W-1:0] word_count,
  output logic             frame_done,
  output logic             overflow
);

  typedef enum logic [1:0] {LOAD, SEND, CRC, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic             last_q, last_d;
  logic             drain_q, drain_d;
  // Set between frames so the next accepted word restarts word_count at 1.
  logic             first_q, first_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;

  logic             s_hs;
  logic             m_hs;
  logic [7:0]       cur_byte;

  always_comb begin
    cur_byte      = word_q[8*idx_q +: 8];
    S_AXIS_TREADY = (state_q == LOAD) || (state_q == DRAIN);
    M_AXIS_TVALID = (state_q == SEND) || (state_q == CRC);
    M_AXIS_TLAST  = (state_q == CRC);
    M_AXIS_TDATA  = 8'h00;
    if (state_q == SEND) begin
      M_AXIS_TDATA = cur_byte;
    end else if (state_q == CRC) begin
      M_AXIS_TDATA = csum_q;
    end
    s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
    m_hs = M_AXIS_TVALID && M_AXIS_TREADY;
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    last_d       = last_q;
    drain_d      = drain_q;
    first_d      = first_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    word_count_d = word_count_q;
    frame_done_d = 1'b0;
    overflow_d   = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_hs) begin
          word_d       = S_AXIS_TDATA;
          last_d       = S_AXIS_TLAST;
          word_count_d = first_q ? CNT_W'(1) : word_count_q + CNT_W'(1);
          first_d      = 1'b0;
          idx_d        = 2'd0;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (m_hs) begin
          csum_d = csum_q ^ cur_byte;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (last_q) begin
              state_d = CRC;
            end else if (word_count_q == CNT_W'(MAX_WORDS)) begin
              // Truncate: close the frame now and swallow the rest of it.
              overflow_d = 1'b1;
              drain_d    = 1'b1;
              state_d    = CRC;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      CRC: begin
        if (m_hs) begin
          frame_done_d = 1'b1;
          csum_d       = 8'h00;
          first_d      = 1'b1;
          drain_d      = 1'b0;
          state_d      = drain_q ? DRAIN : LOAD;
        end
      end
      DRAIN: begin
        if (s_hs && S_AXIS_TLAST) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      word_q       <= 32'h0;
      last_q       <= 1'b0;
      drain_q      <= 1'b0;
      first_q      <= 1'b1;
      idx_q        <= 2'd0;
      csum_q       <= 8'h00;
      word_count_q <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      last_q       <= last_d;
      drain_q      <= drain_d;
      first_q      <= first_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      word_count_q <= word_count_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign word_count = word_count_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_maple_frame_packer.sv
// tb/tb_maple_frame_packer.sv - self-checking bench for maple_frame_packer
module tb_maple_frame_packer;

  localparam int MAXW  = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             S_AXIS_TVALID;
  logic             S_AXIS_TREADY;
  logic             S_AXIS_TLAST;
  logic [31:0]      S_AXIS_TDATA;
  logic             M_AXIS_TVALID;
  logic             M_AXIS_TREADY;
  logic             M_AXIS_TLAST;
  logic [7:0]       M_AXIS_TDATA;
  logic [CNT_W-1:0] word_count;
  logic             frame_done;
  logic             overflow;

  maple_frame_packer #(.MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TDATA(S_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TDATA(M_AXIS_TDATA),
    .word_count(word_count), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [32:0] stim_q[$];   // {tlast, word}
  logic [32:0] in_q[$];
  logic [8:0]  out_q[$];    // {tlast, byte}
  logic [8:0]  exp_q[$];
  int fd_cnt, ov_cnt, stall_viol;
  int exp_frames, exp_ovf, exp_wc;

  // Reference: each frame is its words (at most MAXW of them) split into
  // little-endian bytes followed by the XOR of those bytes marked last.
  task automatic build_model();
    int n;
    logic [7:0] cs;
    logic [7:0] by;
    exp_q.delete();
    exp_frames = 0;
    exp_ovf = 0;
    n = 0;
    cs = 8'h00;
    foreach (stim_q[i]) begin
      if (n < MAXW) begin
        for (int b = 0; b < 4; b++) begin
          by = stim_q[i][8*b +: 8];
          exp_q.push_back({1'b0, by});
          cs = cs ^ by;
        end
        n++;
        exp_wc = n;
      end else if (n == MAXW) begin
        exp_ovf++;
        n++;
      end
      if (stim_q[i][32]) begin
        exp_q.push_back({1'b1, cs});
        exp_frames++;
        cs = 8'h00;
        n = 0;
      end
    end
  endtask

  task automatic start(input bit keep_out);
    in_q = stim_q;
    if (!keep_out) out_q.delete();
    fd_cnt = 0;
    ov_cnt = 0;
    stall_viol = 0;
    build_model();
  endtask

  // Cycle driver: feeds in_q, collects output bytes, counts pulses and
  // notes any change of a stalled output byte.
  task automatic run(input int n_bytes, input bit rnd_ready, input int abort_at);
    int cyc;
    int extra;
    bit prev_stall;
    logic [8:0] prev;
    cyc = 0;
    extra = 0;
    prev_stall = 1'b0;
    prev = '0;
    while (1) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (overflow) ov_cnt++;
      if (prev_stall && (!M_AXIS_TVALID || {M_AXIS_TLAST, M_AXIS_TDATA} !== prev)) stall_viol++;
      if (abort_at > 0 && out_q.size() == abort_at) begin
        reset = 1'b1;
        S_AXIS_TVALID = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      if (out_q.size() >= n_bytes && in_q.size() == 0) begin
        extra++;
        if (extra > 3) begin
          S_AXIS_TVALID = 1'b0;
          return;
        end
      end
      M_AXIS_TREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_q.size() > 0) begin
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TLAST  = in_q[0][32];
        S_AXIS_TDATA  = in_q[0][31:0];
      end else begin
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TDATA  = $urandom;
      end
      #1;
      if (S_AXIS_TVALID && S_AXIS_TREADY) void'(in_q.pop_front());
      if (M_AXIS_TVALID && M_AXIS_TREADY) out_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev = {M_AXIS_TLAST, M_AXIS_TDATA};
      cyc++;
      if (cyc > 4000) begin
        checks++;
        errors++;
        $display("FAIL run_timeout got %0d bytes required %0d", out_q.size(), n_bytes);
        S_AXIS_TVALID = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST = 1'b0;
    S_AXIS_TDATA = 32'h0;
    M_AXIS_TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b required 0", M_AXIS_TVALID); end
    checks++; if (M_AXIS_TDATA !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h required 00", M_AXIS_TDATA); end
    checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b required 0", M_AXIS_TLAST); end
    checks++; if (frame_done !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b required 00", frame_done, overflow); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL reset_word_count got %0d required 0", word_count); end
    checks++; if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL reset_s_tready got %b required 1", S_AXIS_TREADY); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    logic [8:0] req[$];
    req = '{9'h004, 9'h003, 9'h002, 9'h001, 9'h104};
    stim_q = '{{1'b1, 32'h01020304}};
    start(0);
    run(5, 0, 0);
    checks++; if (out_q.size() !== 5) begin errors++; $display("FAIL single_len got %0d required 5", out_q.size()); end
    else foreach (req[i]) begin
      checks++; if (out_q[i] !== req[i]) begin errors++; $display("FAIL single_byte%0d got %h required %h", i, out_q[i], req[i]); end
    end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL single_frame_done got %0d required 1", fd_cnt); end
    checks++; if (word_count !== 3'd1) begin errors++; $display("FAIL single_word_count got %0d required 1", word_count); end
  endtask

  task automatic test_two_words();
    logic [8:0] req[$];
    req = '{9'h0FF, 9'h000, 9'h000, 9'h000, 9'h000, 9'h0FF, 9'h000, 9'h000, 9'h100};
    stim_q = '{{1'b0, 32'h000000FF}, {1'b1, 32'h0000FF00}};
    start(0);
    run(9, 0, 0);
    checks++; if (out_q.size() !== 9) begin errors++; $display("FAIL two_len got %0d required 9", out_q.size()); end
    else foreach (req[i]) begin
      checks++; if (out_q[i] !== req[i]) begin errors++; $display("FAIL two_byte%0d got %h required %h", i, out_q[i], req[i]); end
    end
    checks++; if (word_count !== 3'd2) begin errors++; $display("FAIL two_word_count got %0d required 2", word_count); end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 4; r++) begin
      stim_q = '{{1'b1, 32'h01020304}};
      start(0);
      run(exp_q.size(), 1, 0);
      checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_len got %0d required %0d", out_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
        checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d got %h required %h", i, out_q[i], exp_q[i]); end
      end
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable got %0d changes required 0", stall_viol); end
    end
  endtask

  task automatic test_overflow();
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back({(i == 5), 32'h11111111});
    stim_q.push_back({1'b1, 32'h00000007});
    start(0);
    run(exp_q.size(), 0, 0);
    checks++; if (exp_q.size() !== 22) begin errors++; $display("FAIL ovf_model_len got %0d required 22", exp_q.size()); end
    checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_len got %0d required %0d", out_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got %h required %h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (out_q.size() > 16 && out_q[16] !== 9'h100) begin errors++; $display("FAIL ovf_checksum got %h required 100", out_q[16]); end
    checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ovf_pulses got %0d required 1", ov_cnt); end
    checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL ovf_frame_done got %0d required 2", fd_cnt); end
    checks++; if (word_count !== 3'd1) begin errors++; $display("FAIL ovf_next_word_count got %0d required 1", word_count); end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] req[$];
    stim_q = '{{1'b1, 32'hAABBCCDD}};
    start(0);
    run(5, 0, 2);
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL abort_tvalid got %b required 0", M_AXIS_TVALID); end
    checks++; if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL abort_s_tready got %b required 1", S_AXIS_TREADY); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL abort_word_count got %0d required 0", word_count); end
    req = '{9'h001, 9'h000, 9'h000, 9'h000, 9'h101};
    stim_q = '{{1'b1, 32'h00000001}};
    start(0);
    run(5, 0, 0);
    checks++; if (out_q.size() !== 5) begin errors++; $display("FAIL abort_next_len got %0d required 5", out_q.size()); end
    else foreach (req[i]) begin
      checks++; if (out_q[i] !== req[i]) begin errors++; $display("FAIL abort_next_byte%0d got %h required %h", i, out_q[i], req[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] req[$];
    req = '{9'h005, 9'h000, 9'h000, 9'h000, 9'h105, 9'h00A, 9'h000, 9'h000, 9'h000, 9'h10A};
    stim_q = '{{1'b1, 32'h00000005}, {1'b1, 32'h0000000A}};
    start(0);
    run(10, 0, 0);
    checks++; if (out_q.size() !== 10) begin errors++; $display("FAIL b2b_len got %0d required 10", out_q.size()); end
    else foreach (req[i]) begin
      checks++; if (out_q[i] !== req[i]) begin errors++; $display("FAIL b2b_byte%0d got %h required %h", i, out_q[i], req[i]); end
    end
    checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL b2b_frame_done got %0d required 2", fd_cnt); end
  endtask

  task automatic test_random_frames();
    int nw;
    for (int r = 0; r < 8; r++) begin
      stim_q.delete();
      for (int f = 0; f < 3; f++) begin
        nw = $urandom_range(1, 7);
        for (int w = 0; w < nw; w++) stim_q.push_back({(w == nw - 1), 32'($urandom)});
      end
      start(0);
      run(exp_q.size(), 1, 0);
      checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_len got %0d required %0d", out_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
        checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_byte%0d got %h required %h", i, out_q[i], exp_q[i]); end
      end
      checks++; if (fd_cnt !== exp_frames) begin errors++; $display("FAIL rnd_frame_done got %0d required %0d", fd_cnt, exp_frames); end
      checks++; if (ov_cnt !== exp_ovf) begin errors++; $display("FAIL rnd_overflow got %0d required %0d", ov_cnt, exp_ovf); end
      checks++; if (word_count !== CNT_W'(exp_wc)) begin errors++; $display("FAIL rnd_word_count got %0d required %0d", word_count, exp_wc); end
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL rnd_stable got %0d changes required 0", stall_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
